// File: rtl/wb_extbus_master.sv
// wb_extbus_master: bridges async external byte-bus writes to Wishbone byte writes.
// Optional macro EXTBUS_TIMEOUT_EN bounds each Wishbone cycle to timeout_cycles clocks.
module wb_extbus_master #(
  parameter logic [31:0] base_addr      = 32'h8000_0000,
  parameter int          fifo_aw        = 2,
  parameter logic [31:0] timeout_cycles = 32'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] ext_addr,
  input  logic [7:0]  ext_data,
  input  logic        ext_nwe,
  input  logic        ext_noe,
  input  logic        ext_ncs,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        overflow_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int DEPTH = 1 << fifo_aw;
  localparam logic [fifo_aw:0]   LP_FULL    = (fifo_aw+1)'(DEPTH);
  localparam logic [fifo_aw:0]   LP_CNT_ONE = 1;
  localparam logic [fifo_aw-1:0] LP_PTR_ONE = 1;

  typedef enum logic {
    ST_IDLE,
    ST_CYCLE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // nwe: [0]=stage1, [1]=stage2, [2]=edge-detect stage
  logic [2:0]  r_nwe_sync;
  logic [1:0]  r_ncs_sync;
  logic [12:0] r_addr_s1;
  logic [12:0] r_addr_s2;
  logic [7:0]  r_data_s1;
  logic [7:0]  r_data_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_nwe_sync <= 3'b111;
      r_ncs_sync <= 2'b11;
      r_addr_s1  <= '0;
      r_addr_s2  <= '0;
      r_data_s1  <= '0;
      r_data_s2  <= '0;
    end else begin
      r_nwe_sync <= {r_nwe_sync[1:0], ext_nwe};
      r_ncs_sync <= {r_ncs_sync[0], ext_ncs};
      r_addr_s1  <= ext_addr;
      r_addr_s2  <= r_addr_s1;
      r_data_s1  <= ext_data;
      r_data_s2  <= r_data_s1;
    end
  end

  logic        w_cap;
  logic        r_cap_v;
  logic [20:0] r_cap_ent;

  assign w_cap = r_nwe_sync[1] & ~r_nwe_sync[2] & ~r_ncs_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cap_v   <= 1'b0;
      r_cap_ent <= '0;
    end else begin
      r_cap_v <= w_cap;
      if (w_cap) begin
        r_cap_ent <= {r_addr_s2, r_data_s2};
      end
    end
  end

  logic [20:0]        r_mem [DEPTH];
  logic [fifo_aw-1:0] r_wptr;
  logic [fifo_aw-1:0] r_rptr;
  logic [fifo_aw:0]   r_count;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic [20:0]        w_head;
  logic [12:0]        w_head_addr;
  logic [7:0]         w_head_data;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == LP_FULL);
  assign w_push      = r_cap_v & (~w_full | w_pop);
  assign w_drop      = r_cap_v & w_full & ~w_pop;
  assign w_head      = r_mem[r_rptr];
  assign w_head_addr = w_head[20:8];
  assign w_head_data = w_head[7:0];

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wptr] <= r_cap_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + LP_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + LP_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + LP_CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - LP_CNT_ONE;
      end
    end
  end

  logic w_tmo;
  logic w_unused;

`ifdef EXTBUS_TIMEOUT_EN
  logic [31:0] r_tmo;

  always_ff @(posedge clk) begin
    if (reset || w_pop) begin
      r_tmo <= '0;
    end else if (r_state == ST_CYCLE) begin
      r_tmo <= r_tmo + 32'd1;
    end
  end

  // r_tmo+1 is the number of clocks the cycle has been on the bus
  assign w_tmo    = (r_state == ST_CYCLE) && ((r_tmo + 32'd1) >= timeout_cycles);
  assign w_unused = ^{wb_dat_i, ext_noe};
`else
  assign w_tmo    = 1'b0;
  assign w_unused = ^{wb_dat_i, ext_noe, timeout_cycles};
`endif

  logic w_done;
  logic w_fault;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_fault     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_CYCLE;
        end
      end
      ST_CYCLE: begin
        if (wb_ack_i || wb_err_i || w_tmo) begin
          w_done      = 1'b1;
          w_fault     = wb_err_i | (w_tmo & ~wb_ack_i);
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  logic        r_cyc;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_ovf;
  logic        r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc <= 1'b0;
      r_adr <= '0;
      r_dat <= '0;
      r_sel <= '0;
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_pop) begin
        r_cyc <= 1'b1;
        r_adr <= base_addr + {19'b0, w_head_addr};
        r_sel <= 4'b1000 >> w_head_addr[1:0];
        r_dat <= {4{w_head_data}};
      end else if (w_done) begin
        r_cyc <= 1'b0;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      if (w_done && w_fault) begin
        r_err <= 1'b1;
      end
    end
  end

  assign wb_adr_o   = r_adr;
  assign wb_dat_o   = r_dat;
  assign wb_sel_o   = r_sel;
  assign wb_we_o    = r_cyc;
  assign wb_cyc_o   = r_cyc;
  assign wb_stb_o   = r_cyc;
  assign overflow_o = r_ovf;
  assign err_o      = r_err;
  assign busy_o     = ~w_empty | r_cyc;

endmodule

// File: tb/tb_wb_extbus_master.sv
// tb_wb_extbus_master: vector table, corner sequences and random writes
// against a queue-based model of the external-write to Wishbone mapping.
module tb_wb_extbus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] ext_addr;
  logic [7:0]  ext_data;
  logic        ext_nwe;
  logic        ext_noe;
  logic        ext_ncs;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        overflow_o;
  logic        err_o;
  logic        busy_o;

  always #5 clk = ~clk;

  wb_extbus_master #(
    .base_addr     (32'h8000_0000),
    .fifo_aw       (2),
    .timeout_cycles(32'd255)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ext_addr  (ext_addr),
    .ext_data  (ext_data),
    .ext_nwe   (ext_nwe),
    .ext_noe   (ext_noe),
    .ext_ncs   (ext_ncs),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_o  (wb_sel_o),
    .wb_we_o   (wb_we_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i),
    .overflow_o(overflow_o),
    .err_o     (err_o),
    .busy_o    (busy_o)
  );

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        we;
    int          len;
  } txn_t;

  typedef struct {
    logic [12:0] a;
    logic [7:0]  d;
    logic        ncs;
    int          n;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } vec_t;

  txn_t got_q[$];
  txn_t mon_t;
  int   n_pass = 0;
  int   n_total = 0;
  int   ack_wmax = 0;
  bit   ack_en = 1'b1;
  bit   err_once = 1'b0;
  bit   resp = 1'b0;
  int   wcnt = 0;
  int   cur_wait = 0;
  int   cyc_rises = 0;
  logic prev_cyc = 1'b0;

  function automatic void chk(string name, logic [71:0] act, logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Expected {adr, sel, dat} from the byte address/data, lane 0 = MSB.
  function automatic logic [67:0] model(logic [12:0] a, logic [7:0] d);
    int          lane = int'(a) % 4;
    logic [31:0] adr  = 32'h8000_0000 + 32'(a);
    logic [3:0]  sel  = 4'(1 << (3 - lane));
    logic [31:0] dat  = 32'(d) * 32'h0101_0101;
    return {adr, sel, dat};
  endfunction

  function automatic logic [67:0] pk(txn_t t);
    return {t.adr, t.sel, t.dat};
  endfunction

  // Slave responder / monitor
  always @(negedge clk) begin
    if (wb_cyc_o && !prev_cyc) cyc_rises++;
    prev_cyc = wb_cyc_o;
    if (resp) begin
      resp = 1'b0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wcnt = 0;
    end else if (!wb_cyc_o) begin
      wcnt = 0;
      cur_wait = int'($urandom_range(ack_wmax, 0));
    end else if (ack_en) begin
      if (wcnt >= cur_wait) begin
        mon_t.adr = wb_adr_o;
        mon_t.sel = wb_sel_o;
        mon_t.dat = wb_dat_o;
        mon_t.we  = wb_we_o & wb_stb_o;
        mon_t.len = wcnt + 1;
        got_q.push_back(mon_t);
        wb_ack_i = ~err_once;
        wb_err_i = err_once;
        err_once = 1'b0;
        resp = 1'b1;
      end else begin
        wcnt++;
      end
    end
  end

  task automatic ext_write(input logic [12:0] a, input logic [7:0] d,
                           input logic cs_n, input int lo, input int hi);
    @(negedge clk);
    ext_addr = a;
    ext_data = d;
    ext_ncs  = cs_n;
    ext_nwe  = 1'b0;
    repeat (lo) @(negedge clk);
    ext_nwe = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!wb_cyc_o && !busy_o) break;
    end
    chk("idle_wait", {70'd0, busy_o, wb_cyc_o}, 72'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  vec_t        vt[6];
  logic [67:0] exp_q[$];
  logic [12:0] ra;
  logic [7:0]  rd;
  logic        rc;
  int          lat;
  logic        b5;
  logic        b6;
  logic        c6;
  int          r0;

  initial begin
    vt[0] = '{13'h0000, 8'h11, 1'b0, 1, 32'h8000_0000, 4'b1000, 32'h1111_1111};
    vt[1] = '{13'h0001, 8'h22, 1'b0, 1, 32'h8000_0001, 4'b0100, 32'h2222_2222};
    vt[2] = '{13'h0002, 8'h33, 1'b0, 1, 32'h8000_0002, 4'b0010, 32'h3333_3333};
    vt[3] = '{13'h0003, 8'h44, 1'b0, 1, 32'h8000_0003, 4'b0001, 32'h4444_4444};
    vt[4] = '{13'h0005, 8'h55, 1'b1, 0, 32'h0,         4'b0000, 32'h0};
    vt[5] = '{13'h1FFF, 8'h3C, 1'b0, 1, 32'h8000_1FFF, 4'b0001, 32'h3C3C_3C3C};

    reset    = 1'b1;
    ext_addr = '0;
    ext_data = '0;
    ext_nwe  = 1'b1;
    ext_noe  = 1'b1;
    ext_ncs  = 1'b1;
    wb_dat_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_sel", wb_sel_o, 0);
    chk("rst_flags", {overflow_o, err_o, busy_o}, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single write with pipeline latency and zero-wait ack
    got_q.delete();
    @(negedge clk);
    ext_addr = 13'h0013;
    ext_data = 8'hA5;
    ext_ncs  = 1'b0;
    ext_nwe  = 1'b0;
    repeat (4) @(negedge clk);
    ext_nwe = 1'b1;
    lat = 0;
    b5 = 1'b0;
    b6 = 1'b1;
    c6 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (wb_cyc_o && lat == 0) lat = i;
      if (i == 5) b5 = busy_o;
      if (i == 6) begin
        b6 = busy_o;
        c6 = wb_cyc_o;
      end
    end
    chk("single_latency", lat, 5);
    chk("single_busy_on", b5, 1);
    chk("single_busy_off", b6, 0);
    chk("single_cyc_off", c6, 0);
    chk("single_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      chk("single_txn", pk(got_q[0]), 68'h8000_0013_1_A5A5A5A5);
      chk("single_we", got_q[0].we, 1);
      chk("single_len", got_q[0].len, 1);
    end

    // Lanes and chip select vectors
    for (int i = 0; i < 6; i++) begin
      got_q.delete();
      ext_write(vt[i].a, vt[i].d, vt[i].ncs, 3, 3);
      repeat (15) @(negedge clk);
      chk("vec_count", got_q.size(), vt[i].n);
      if (vt[i].n == 1 && got_q.size() > 0)
        chk("vec_txn", pk(got_q[0]), {vt[i].adr, vt[i].sel, vt[i].dat});
    end

    // Error on first cycle, second proceeds
    ack_en = 1'b0;
    got_q.delete();
    chk("err_pre", err_o, 0);
    ext_write(13'h0100, 8'h5A, 1'b0, 3, 3);
    ext_write(13'h0102, 8'hC3, 1'b0, 3, 3);
    repeat (8) @(negedge clk);
    err_once = 1'b1;
    ack_en = 1'b1;
    wait_idle(50);
    chk("err_set", err_o, 1);
    chk("err_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("err_txn0", pk(got_q[0]), model(13'h0100, 8'h5A));
      chk("err_txn1", pk(got_q[1]), model(13'h0102, 8'hC3));
    end

    // Overflow: 1 in flight + 4 queued, 6th dropped
    ack_en = 1'b0;
    got_q.delete();
    chk("ovf_pre", overflow_o, 0);
    for (int i = 0; i < 6; i++)
      ext_write(13'(13'h0200 + i), 8'(8'hA0 + i), 1'b0, 3, 3);
    repeat (8) @(negedge clk);
    chk("ovf_set", overflow_o, 1);
    chk("ovf_busy", busy_o, 1);
    chk("ovf_cyc_held", wb_cyc_o, 1);
    chk("ovf_no_ack_yet", got_q.size(), 0);
    ack_en = 1'b1;
    wait_idle(100);
    chk("ovf_drain_count", got_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got_q.size())
        chk("ovf_order", pk(got_q[i]), model(13'(13'h0200 + i), 8'(8'hA0 + i)));

    // Reset during a cycle with 2 entries queued
    ack_en = 1'b0;
    got_q.delete();
    for (int i = 0; i < 3; i++)
      ext_write(13'(13'h0300 + i), 8'(8'h70 + i), 1'b0, 3, 3);
    repeat (8) @(negedge clk);
    chk("rmid_cyc_before", wb_cyc_o, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rmid_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
    chk("rmid_adr", wb_adr_o, 0);
    chk("rmid_dat", wb_dat_o, 0);
    chk("rmid_sel", wb_sel_o, 0);
    chk("rmid_flags", {overflow_o, err_o, busy_o}, 0);
    reset = 1'b0;
    ack_en = 1'b1;
    r0 = cyc_rises;
    repeat (30) @(negedge clk);
    chk("rmid_no_cycles", cyc_rises - r0, 0);
    chk("rmid_no_txn", got_q.size(), 0);

    // Randomized writes with random slave wait states
    ack_wmax = 2;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      ra = 13'($urandom);
      rd = 8'($urandom);
      rc = ($urandom_range(4, 0) == 0);
      ext_write(ra, rd, rc, int'($urandom_range(5, 3)), int'($urandom_range(4, 2)));
      if (!rc) exp_q.push_back(model(ra, rd));
    end
    repeat (6) @(negedge clk);
    wait_idle(200);
    chk("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size())
        chk("rand_txn", pk(got_q[i]), exp_q[i]);
    chk("rand_flags", {overflow_o, err_o}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
